transmitter_queue: RTL and testbench
====================================

Name: transmitter_queue

Overview:
- Sending end of the ring interconnect node: the node controller pushes outbound words, each tagged with a destination link (left, right, or self/off-network), into a shared FIFO.
- One sequencer pops words in order and drives each onto its link, holding the data and a valid strobe for a fixed number of cycles so the far-end input conditioner registers the word cleanly.
- A fixed gap follows each word before the next one is sent.

Parameters:
- width, 32, data word width.
- depth, 4, FIFO entries; must be a power of 2, at least 2.
- hold_cycles, 3, cycles each word and its valid strobe stay asserted on a link; at least 1.
- gap_cycles, 2, idle cycles after each word before the next pop; at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- in_sig  input  width  word from controller.
- wr_en  input  1  push request.
- dest  input  2  link select: 00 left, 01 self, 10 right, 11 invalid (same encoding as the cycler).
- full  output  1  count == depth.
- empty  output  1  count == 0.
- count  output  clog2(depth)+1  FIFO occupancy.
- drop  output  1  one-cycle pulse: the previous edge's write was rejected.
- busy  output  1  sequencer not IDLE.
- out_sig_left, out_sig_right, out_sig_self  output  width  link data.
- out_valid_left, out_valid_right, out_valid_self  output  1  link strobes.

Behaviour:
- Reset, asynchronous: all outputs go 0 immediately except empty, which goes 1. Pointers and count are cleared, state becomes IDLE, and queued words are discarded. This applies mid-DRIVE or mid-GAP; link outputs drop without waiting for a clock.
- All outputs are registered.
- Push:
  - At a clk edge with wr_en=1, the word {dest, in_sig} is stored at the write pointer when the pre-edge full=0 and dest!=11.
  - The write is rejected when full=1 or dest=11. A rejected write stores nothing and sets drop=1 for exactly the following cycle.
  - A write while full is rejected even if a pop occurs on the same edge.
- Pointers wrap modulo depth. Simultaneous accepted push and pop leaves count unchanged. Words are delivered strictly in FIFO order.
- States:
  - IDLE: on an edge where the pre-edge count>0, pop the head, load the selected link's out_sig and assert its out_valid, load the hold counter, and go to DRIVE.
  - DRIVE: the selected link's data and valid are held stable for exactly hold_cycles cycles. On the edge ending the last hold cycle, clear that link's data and valid to 0 and go to GAP.
  - GAP: lasts exactly gap_cycles cycles. On the final edge, if count>0 pop directly into DRIVE; otherwise go to IDLE.
- Timing:
  - Latency: a word written at edge N into an empty FIFO while IDLE appears on its link after edge N+1.
  - Period when backed up: hold_cycles+gap_cycles cycles per word.
- At most one link is active at a time. Non-selected links always show data 0 and valid 0.
- busy = (state != IDLE).
- Link outputs never carry X or Z after reset.

Test Plan (depth=4, hold_cycles=3, gap_cycles=2; edges counted from the first edge after reset release):
- Single word: write 0xDEADBEEF with dest=10 at edge 1.
  - out_sig_right=0xDEADBEEF and out_valid_right=1 after edges 2, 3, 4; both 0 after edge 5.
  - busy=1 from edge 2 through edge 6; left and self links stay 0.
- Back-to-back: write A (00), B (01), C (10) at edges 1, 2, 3.
  - Left valid after edges 2–4, self valid after edges 7–9, right valid after edges 12–14, each carrying its own data.
  - empty=1 after edge 12.
- Overflow: write words 1..6 with dest=00 at edges 1..6.
  - count=4 and full=1 after edge 5; the edge-6 write is rejected, so drop=1 after edge 6 only and count stays 4.
  - Words 1..5 appear on the left link in order; word 6 never appears.
- Invalid destination: write 0x12345678 with dest=11 while idle.
  - drop pulses for one cycle; count=0 and empty=1 stay unchanged; no valid asserts on any link.
- Reset mid-operation: from the single-word case, assert reset between edges 3 and 4 with 2 more words queued.
  - out_valid_right and out_sig_right go 0 without a clock edge; count=0, empty=1.
  - After release, no link activity occurs without new writes.
- Wrap-around: 10 words with rotating dest values, each written after the previous one is delivered.
  - All 10 are delivered in order to the correct links; pointers wrap twice; no drops.

Source files
------------

// File: rtl/transmitter_queue.sv
// Outbound side of a ring node: a shared FIFO of {dest, word} entries drained by a
// sequencer that holds each word on its link for hold_cycles, then idles for gap_cycles.
module transmitter_queue #(
  parameter int unsigned width       = 32,
  parameter int unsigned depth       = 4,
  parameter int unsigned hold_cycles = 3,
  parameter int unsigned gap_cycles  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [width-1:0]         in_sig,
  input  logic                     wr_en,
  input  logic [1:0]               dest,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count,
  output logic                     drop,
  output logic                     busy,
  output logic [width-1:0]         out_sig_left,
  output logic [width-1:0]         out_sig_right,
  output logic [width-1:0]         out_sig_self,
  output logic                     out_valid_left,
  output logic                     out_valid_right,
  output logic                     out_valid_self
);

  localparam int unsigned aw   = $clog2(depth);
  localparam int unsigned cw   = aw + 1;
  localparam int unsigned ew   = width + 2;
  localparam int unsigned tmax = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
  localparam int unsigned tw   = $clog2(tmax) + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t            state, state_nxt;
  logic [tw-1:0]     timer, timer_nxt;
  logic [aw-1:0]     wr_ptr, rd_ptr;
  logic [ew-1:0]     mem [depth];
  logic [ew-1:0]     head_c;
  logic              push_c, pop_c;
  logic [cw-1:0]     count_nxt;
  logic [width-1:0]  left_nxt, right_nxt, self_nxt;
  logic              vleft_nxt, vright_nxt, vself_nxt;

  // Accept decision uses the registered (pre-edge) full flag, so a same-edge pop never rescues a write.
  assign push_c    = wr_en && !full && (dest != 2'b11);
  assign count_nxt = count + cw'(push_c) - cw'(pop_c);
  assign head_c    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {dest, in_sig};
  end

  // State register, timer and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      if (push_c) wr_ptr <= wr_ptr + aw'(1);
      if (pop_c)  rd_ptr <= rd_ptr + aw'(1);
    end
  end

  // Next-state logic; timer counts down to 0 on the last cycle of each phase
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop_c     = 1'b1;
          state_nxt = DRIVE;
          timer_nxt = tw'(hold_cycles - 1);
        end
      end
      DRIVE: begin
        if (timer == '0) begin
          state_nxt = GAP;
          timer_nxt = tw'(gap_cycles - 1);
        end else begin
          timer_nxt = timer - tw'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
          if (count != '0) begin
            pop_c     = 1'b1;
            state_nxt = DRIVE;
            timer_nxt = tw'(hold_cycles - 1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - tw'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Link output next values: load on pop, clear at the end of DRIVE, otherwise hold
  always_comb begin
    left_nxt   = out_sig_left;
    right_nxt  = out_sig_right;
    self_nxt   = out_sig_self;
    vleft_nxt  = out_valid_left;
    vright_nxt = out_valid_right;
    vself_nxt  = out_valid_self;
    if (pop_c) begin
      left_nxt   = '0;
      right_nxt  = '0;
      self_nxt   = '0;
      vleft_nxt  = 1'b0;
      vright_nxt = 1'b0;
      vself_nxt  = 1'b0;
      case (head_c[width+1:width])
        2'b00: begin left_nxt  = head_c[width-1:0]; vleft_nxt  = 1'b1; end
        2'b01: begin self_nxt  = head_c[width-1:0]; vself_nxt  = 1'b1; end
        2'b10: begin right_nxt = head_c[width-1:0]; vright_nxt = 1'b1; end
        default: ;
      endcase
    end else if (state == DRIVE && timer == '0) begin
      left_nxt   = '0;
      right_nxt  = '0;
      self_nxt   = '0;
      vleft_nxt  = 1'b0;
      vright_nxt = 1'b0;
      vself_nxt  = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count           <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      drop            <= 1'b0;
      busy            <= 1'b0;
      out_sig_left    <= '0;
      out_sig_right   <= '0;
      out_sig_self    <= '0;
      out_valid_left  <= 1'b0;
      out_valid_right <= 1'b0;
      out_valid_self  <= 1'b0;
    end else begin
      count           <= count_nxt;
      full            <= (count_nxt == cw'(depth));
      empty           <= (count_nxt == '0);
      drop            <= wr_en && !push_c;
      busy            <= (state_nxt != IDLE);
      out_sig_left    <= left_nxt;
      out_sig_right   <= right_nxt;
      out_sig_self    <= self_nxt;
      out_valid_left  <= vleft_nxt;
      out_valid_right <= vright_nxt;
      out_valid_self  <= vself_nxt;
    end
  end

endmodule

// File: tb/tb_transmitter_queue.sv
// Bench for transmitter_queue: per-edge vector table, hand-written corner sequences,
// and a link monitor that checks delivered words against a FIFO scoreboard.
module tb_transmitter_queue;

  logic        clk;
  logic        reset;
  logic [31:0] in_sig;
  logic        wr_en;
  logic [1:0]  dest;
  logic        full, empty, drop, busy;
  logic [2:0]  count;
  logic [31:0] out_sig_left, out_sig_right, out_sig_self;
  logic        out_valid_left, out_valid_right, out_valid_self;

  int checks   = 0;
  int failures = 0;
  logic [33:0] sb_q[$];

  transmitter_queue #(.width(32), .depth(4), .hold_cycles(3), .gap_cycles(2)) dut (
    .clk(clk), .reset(reset), .in_sig(in_sig), .wr_en(wr_en), .dest(dest),
    .full(full), .empty(empty), .count(count), .drop(drop), .busy(busy),
    .out_sig_left(out_sig_left), .out_sig_right(out_sig_right), .out_sig_self(out_sig_self),
    .out_valid_left(out_valid_left), .out_valid_right(out_valid_right),
    .out_valid_self(out_valid_self)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        w;
    logic [1:0]  d;
    logic [31:0] x;
    logic        acc;
    logic [2:0]  cnt;
    logic        f;
    logic        e;
    logic        dr;
    logic        b;
    logic [2:0]  v;   // {right, self, left}
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic w, input logic [1:0] d,
                              input logic [31:0] x, input logic acc, input logic [2:0] cnt,
                              input logic f, input logic e, input logic dr, input logic b,
                              input logic [2:0] v);
    vec_t r;
    r.rst = rst; r.w = w; r.d = d; r.x = x; r.acc = acc; r.cnt = cnt;
    r.f = f; r.e = e; r.dr = dr; r.b = b; r.v = v;
    return r;
  endfunction

  // Drive one edge's inputs, record accepted words, then sample 1 time unit after the edge
  task automatic step(input logic w, input logic [1:0] d, input logic [31:0] x, input logic acc);
    wr_en  = w;
    dest   = d;
    in_sig = x;
    if (w && acc) sb_q.push_back({d, x});
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(empty && !busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idle_in_budget", (n < budget), 1'b1);
  endtask

  // Link monitor: one-hot links, zero data on inactive links, scoreboard order, hold length
  initial begin
    logic [2:0]  v, pv, ev;
    logic [31:0] d;
    logic [33:0] cur;
    int          hl;
    pv = '0; hl = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = '0;
        hl = 0;
      end else begin
        v = {out_valid_right, out_valid_self, out_valid_left};
        d = v[0] ? out_sig_left : (v[1] ? out_sig_self : out_sig_right);
        if (!v[0]) chk("inactive_left_data", out_sig_left, 0);
        if (!v[1]) chk("inactive_self_data", out_sig_self, 0);
        if (!v[2]) chk("inactive_right_data", out_sig_right, 0);
        if (v != 3'b000) begin
          chk("link_onehot", $countones(v), 1);
          if (pv == 3'b000) begin
            chk("sb_has_entry", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
              cur = sb_q.pop_front();
              ev = (cur[33:32] == 2'b00) ? 3'b001 : (cur[33:32] == 2'b01) ? 3'b010 : 3'b100;
              chk("word_link", v, ev);
              chk("word_data", d, cur[31:0]);
            end
            hl = 1;
          end else begin
            hl++;
            chk("hold_stable", {v, d}, {pv, cur[31:0]});
          end
        end else if (pv != 3'b000) begin
          chk("hold_len", hl, 3);
        end
        pv = v;
      end
    end
  end

  vec_t tbl[$];

  initial begin
    reset  = 1'b0;
    wr_en  = 1'b0;
    dest   = 2'b00;
    in_sig = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_empty", empty, 1'b1);
    chk("reset_zero_outs", {full, count, drop, busy, out_valid_left, out_valid_right,
                            out_valid_self}, '0);
    chk("reset_zero_data", {out_sig_left, out_sig_right}, '0);

    //          rst  w   d      data          acc cnt f  e  dr b  v
    // Single word to right link
    tbl.push_back(mk(1, 1, 2'b10, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 3'b000));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 1, 3'b100));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 1, 3'b100));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 1, 3'b100));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 1, 3'b000));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 1, 3'b000));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 0, 3'b000));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 0, 3'b000));
    // Invalid destination
    tbl.push_back(mk(1, 1, 2'b11, 32'h12345678, 0, 0, 0, 1, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 0, 1, 0, 0, 3'b000));
    // Overflow: words 1..6 to left, sixth rejected
    tbl.push_back(mk(1, 1, 2'b00, 32'd1,        1, 1, 0, 0, 0, 0, 3'b000));
    tbl.push_back(mk(0, 1, 2'b00, 32'd2,        1, 1, 0, 0, 0, 1, 3'b001));
    tbl.push_back(mk(0, 1, 2'b00, 32'd3,        1, 2, 0, 0, 0, 1, 3'b001));
    tbl.push_back(mk(0, 1, 2'b00, 32'd4,        1, 3, 0, 0, 0, 1, 3'b001));
    tbl.push_back(mk(0, 1, 2'b00, 32'd5,        1, 4, 1, 0, 0, 1, 3'b000));
    tbl.push_back(mk(0, 1, 2'b00, 32'd6,        0, 4, 1, 0, 1, 1, 3'b000));
    tbl.push_back(mk(0, 0, 2'b00, 32'h0,        0, 3, 0, 0, 0, 1, 3'b001));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].w, tbl[i].d, tbl[i].x, tbl[i].acc);
      chk($sformatf("row%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("row%0d_full", i), full, tbl[i].f);
      chk($sformatf("row%0d_empty", i), empty, tbl[i].e);
      chk($sformatf("row%0d_drop", i), drop, tbl[i].dr);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("row%0d_valid", i), {out_valid_right, out_valid_self, out_valid_left},
          tbl[i].v);
    end
    wait_idle(60);
    chk("overflow_drained", sb_q.size(), 0);

    // Back-to-back: A left, B self, C right at edges 1..3
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      logic [2:0] ve;
      case (e)
        1: step(1'b1, 2'b00, 32'hAAAA0001, 1'b1);
        2: step(1'b1, 2'b01, 32'hBBBB0002, 1'b1);
        3: step(1'b1, 2'b10, 32'hCCCC0003, 1'b1);
        default: step(1'b0, 2'b00, 32'h0, 1'b0);
      endcase
      ve = (e >= 2 && e <= 4) ? 3'b001 : (e >= 7 && e <= 9) ? 3'b010 :
           (e >= 12 && e <= 14) ? 3'b100 : 3'b000;
      chk($sformatf("b2b_e%0d_valid", e), {out_valid_right, out_valid_self, out_valid_left}, ve);
      if (e == 11) chk("b2b_e11_not_empty", empty, 1'b0);
      if (e == 12) chk("b2b_e12_empty", empty, 1'b1);
    end

    // Reset in the middle of DRIVE with two words still queued
    do_reset();
    step(1'b1, 2'b10, 32'hDEADBEEF, 1'b1);
    step(1'b1, 2'b10, 32'h11110001, 1'b1);
    step(1'b1, 2'b10, 32'h11110002, 1'b1);
    chk("mid_valid_before_reset", out_valid_right, 1'b1);
    chk("mid_count_before_reset", count, 2);
    #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    chk("mid_reset_valid", out_valid_right, 1'b0);
    chk("mid_reset_data", out_sig_right, 0);
    chk("mid_reset_count", count, 0);
    chk("mid_reset_empty", empty, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b00, 32'h0, 1'b0);
      chk("post_reset_quiet", {busy, out_valid_left, out_valid_right, out_valid_self}, 4'b0000);
    end

    // Wrap-around: ten words, rotating destinations, one at a time
    for (int k = 0; k < 10; k++) begin
      logic [1:0] dk;
      dk = 2'(k % 3);
      step(1'b1, dk, 32'hA5000000 + 32'(k), 1'b1);
      chk($sformatf("wrap%0d_no_drop", k), drop, 1'b0);
      wait_idle(20);
    end
    chk("wrap_drained", sb_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
